// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA 640x480 timing constants and decode helpers (package vga_timing_pkg).
// Also imported by the sprite controllers.
package vga_timing_pkg;

    typedef logic [9:0] cnt_t;

    localparam int unsigned CLK_DIV_DEF = 4;
    localparam int unsigned H_TOTAL_DEF = 800;
    localparam int unsigned V_TOTAL_DEF = 525;

    localparam cnt_t H_VIS_START = 10'd144;
    localparam cnt_t H_VIS_END   = 10'd783;
    localparam cnt_t V_VIS_START = 10'd35;
    localparam cnt_t V_VIS_END   = 10'd514;
    localparam cnt_t H_SYNC_W    = 10'd96;
    localparam cnt_t V_SYNC_W    = 10'd2;

    function automatic logic in_visible(input cnt_t h, input cnt_t v);
        return (h >= H_VIS_START) && (h <= H_VIS_END) &&
               (v >= V_VIS_START) && (v <= V_VIS_END);
    endfunction

    // Sync outputs are active-low: 0 while inside the sync pulse.
    function automatic logic h_sync_n(input cnt_t h);
        return h >= H_SYNC_W;
    endfunction

    function automatic logic v_sync_n(input cnt_t v);
        return v >= V_SYNC_W;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator to its consumers.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    cnt_t        hCount;
    cnt_t        vCount;
    logic        bright;
    logic        hSync;
    logic        vSync;
    logic        pix_tick;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        output hCount, vCount, bright, hSync, vSync, pix_tick, frame_start, frame_cnt
    );

    modport slave (
        input hCount, vCount, bright, hSync, vSync, pix_tick, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and flags the last count as pix_tick.
module vga_pix_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Gated by rst so CLK_DIV=1 (divider pinned at its last value) stays quiet in reset.
    assign pix_tick_o = rst & (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters with registered bright/sync/frame_start.
// Optional completed-frame counter enabled by macro VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned H_TOTAL = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga_o
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    logic tick;
    cnt_t h_q, h_d;
    cnt_t v_q, v_d;
    logic bright_q, bright_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic fs_q, fs_d;

    vga_pix_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_tick (
        .clk        (clk),
        .rst        (rst),
        .pix_tick_o (tick)
    );

    // Decode from the next-state counts so bright/syncs land in the same clk as the counts.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fs_d = 1'b0;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        bright_d = in_visible(h_d, v_d);
        hsync_d  = h_sync_n(h_d);
        vsync_d  = v_sync_n(v_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q      <= '0;
            v_q      <= '0;
            bright_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            bright_q <= bright_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fs_q     <= fs_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fs_d ? fcnt_q + 16'd1 : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign vga_o.frame_cnt = fcnt_q;
`else
    assign vga_o.frame_cnt = '0;
`endif

    assign vga_o.hCount      = h_q;
    assign vga_o.vCount      = v_q;
    assign vga_o.bright      = bright_q;
    assign vga_o.hSync       = hsync_q;
    assign vga_o.vSync       = vsync_q;
    assign vga_o.pix_tick    = tick;
    assign vga_o.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing at CLK_DIV=4 and 1, plus a shrunken frame.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_FRAME_CNT_EN
    localparam int unsigned FC_ON = 1;
`else
    localparam int unsigned FC_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst4, rst1, rsts;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if4 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if ifs ();

    vga_timing_gen #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst4), .vga_o(if4));
    vga_timing_gen #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst1), .vga_o(if1));
    vga_timing_gen #(.CLK_DIV(2), .H_TOTAL(20), .V_TOTAL(10)) duts (.clk(clk), .rst(rsts), .vga_o(ifs));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w, fs, nb, maxh, maxv;

        rst4 = 1'b0;
        rst1 = 1'b0;
        rsts = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_h",      if4.hCount,      0);
        chk("rst_v",      if4.vCount,      0);
        chk("rst_bright", if4.bright,      0);
        chk("rst_hsync",  if4.hSync,       0);
        chk("rst_vsync",  if4.vSync,       0);
        chk("rst_tick",   if4.pix_tick,    0);
        chk("rst_fs",     if4.frame_start, 0);
        chk("rst_fcnt",   if4.frame_cnt,   0);
        chk("rst_tick_div1", if1.pix_tick, 0);

        // CLK_DIV=4: tick sampled at edges 4,8,12; hCount steps one edge later
        rst4 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("d4_tick_k%0d", k), if4.pix_tick, (k % 4 == 3) ? 1 : 0);
            chk($sformatf("d4_h_k%0d", k),    if4.hCount,   k / 4);
        end
        chk("d4_hsync_early", if4.hSync, 0);

        w = 0;
        while (if4.hCount != 95 && w < 1000) begin @(negedge clk); w++; end
        chk("d4_reach_h95", if4.hCount, 95);
        chk("d4_hsync_h95", if4.hSync,  0);
        w = 0;
        while (if4.hCount != 96 && w < 10) begin @(negedge clk); w++; end
        chk("d4_reach_h96", if4.hCount, 96);
        chk("d4_hsync_h96", if4.hSync,  1);
        chk("d4_bright_h96", if4.bright, 0);

        w = 0; fs = 0;
        while (!(if4.hCount == 799 && if4.vCount == 0) && w < 4000) begin
            @(negedge clk); w++; fs += if4.frame_start;
        end
        chk("d4_reach_799_0", (if4.hCount == 799 && if4.vCount == 0) ? 1 : 0, 1);
        chk("d4_vsync_v0", if4.vSync, 0);
        w = 0;
        while (if4.hCount == 799 && w < 10) begin @(negedge clk); w++; fs += if4.frame_start; end
        chk("d4_wrap_h",    if4.hCount,      0);
        chk("d4_wrap_v",    if4.vCount,      1);
        chk("d4_wrap_fs",   if4.frame_start, 0);
        chk("d4_wrap_fcnt", if4.frame_cnt,   0);
        chk("d4_vsync_v1",  if4.vSync,       0);
        w = 0;
        while (if4.vCount != 2 && w < 4000) begin @(negedge clk); w++; fs += if4.frame_start; end
        chk("d4_reach_v2", if4.vCount, 2);
        chk("d4_vsync_v2", if4.vSync,  1);
        chk("d4_no_fs",    fs,         0);
        rst4 = 1'b0;

        // CLK_DIV=1: counts advance every clk, bright window edges on line 35
        rst1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("d1_h_k%0d", k), if1.hCount,   k);
            chk($sformatf("d1_tick_k%0d", k), if1.pix_tick, 1);
        end
        w = 0; nb = 0;
        while (!(if1.hCount == 143 && if1.vCount == 35) && w < 30000) begin
            nb += if1.bright; @(negedge clk); w++;
        end
        chk("d1_reach_143_35", (if1.hCount == 143 && if1.vCount == 35) ? 1 : 0, 1);
        chk("d1_no_bright_before", nb, 0);
        chk("d1_bright_143", if1.bright, 0);
        @(negedge clk);
        chk("d1_h144", if1.hCount, 144);
        chk("d1_bright_144", if1.bright, 1);
        w = 0; nb = 0;
        while (if1.hCount != 784 && w < 1000) begin
            nb += if1.bright; @(negedge clk); w++;
        end
        chk("d1_bright_cnt_line35", nb, 640);
        chk("d1_h784", if1.hCount, 784);
        chk("d1_bright_784", if1.bright, 0);
        chk("d1_v35", if1.vCount, 35);
        chk("d1_hsync_784", if1.hSync, 1);
        chk("d1_vsync_35", if1.vSync, 1);
        rst1 = 1'b0;

        // Shrunken 20x10 frame at CLK_DIV=2: wraps, frame_start, frame_cnt, mid-frame reset
        rsts = 1'b1;
        w = 0; fs = 0; maxh = 0; maxv = 0;
        while (!(ifs.hCount == 19 && ifs.vCount == 9) && w < 1000) begin
            @(negedge clk); w++;
            fs += ifs.frame_start;
            if (ifs.hCount > maxh) maxh = ifs.hCount;
            if (ifs.vCount > maxv) maxv = ifs.vCount;
        end
        chk("s_reach_end", (ifs.hCount == 19 && ifs.vCount == 9) ? 1 : 0, 1);
        chk("s_max_h", maxh, 19);
        chk("s_max_v", maxv, 9);
        chk("s_no_fs_first", fs, 0);
        w = 0;
        while (ifs.hCount == 19 && w < 10) begin @(negedge clk); w++; end
        chk("s_wrap_h", ifs.hCount, 0);
        chk("s_wrap_v", ifs.vCount, 0);
        chk("s_wrap_fs", ifs.frame_start, 1);
        chk("s_wrap_fcnt", ifs.frame_cnt, FC_ON * 1);
        @(negedge clk);
        chk("s_fs_one_clk", ifs.frame_start, 0);
        chk("s_hold_h", ifs.hCount, 0);
        chk("s_hold_fcnt", ifs.frame_cnt, FC_ON * 1);
        w = 0;
        while (ifs.frame_start != 1'b1 && w < 1000) begin @(negedge clk); w++; end
        chk("s_second_fs", ifs.frame_start, 1);
        chk("s_second_fcnt", ifs.frame_cnt, FC_ON * 2);

        w = 0;
        while (!(ifs.hCount == 10 && ifs.vCount == 5) && w < 1000) begin @(negedge clk); w++; end
        chk("s_reach_10_5", (ifs.hCount == 10 && ifs.vCount == 5) ? 1 : 0, 1);
        rsts = 1'b0;
        @(negedge clk);
        chk("s_mrst_h",      ifs.hCount,      0);
        chk("s_mrst_v",      ifs.vCount,      0);
        chk("s_mrst_bright", ifs.bright,      0);
        chk("s_mrst_hsync",  ifs.hSync,       0);
        chk("s_mrst_vsync",  ifs.vSync,       0);
        chk("s_mrst_tick",   ifs.pix_tick,    0);
        chk("s_mrst_fs",     ifs.frame_start, 0);
        chk("s_mrst_fcnt",   ifs.frame_cnt,   0);
        rsts = 1'b1;
        fs = 0;
        repeat (2) begin @(negedge clk); fs += ifs.frame_start; end
        chk("s_restart_h", ifs.hCount, 1);
        chk("s_restart_v", ifs.vCount, 0);
        chk("s_restart_fs", fs, 0);
        chk("s_restart_fcnt", ifs.frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz to 25 MHz); legal 1..16.
REQ-002 Parameter H_TOTAL, default 800: pixel ticks per line.
REQ-003 Parameter V_TOTAL, default 525: lines per frame.
REQ-004 Port clk  input  1: single system clock; all logic on posedge clk.
REQ-005 Port rst  input  1: reset, synchronous and active-low.
REQ-006 Port hCount  output  10: horizontal pixel position, 0..H_TOTAL-1.
REQ-007 Port vCount  output  10: vertical line position, 0..V_TOTAL-1.
REQ-008 Port bright  output  1: high inside the 640x480 visible window.
REQ-009 Port hSync  output  1: horizontal sync, active-low.
REQ-010 Port vSync  output  1: vertical sync, active-low.
REQ-011 Port pix_tick  output  1: one-clk pulse marking each pixel advance.
REQ-012 Port frame_start  output  1: one-clk pulse when hCount=0 and vCount=0 are first presented.
REQ-013 Port frame_cnt  output  16: completed-frame counter (see Configuration).

Function
REQ-014 Divider counts 0..CLK_DIV-1 on every clk and wraps; pix_tick=1 in the clk where the divider equals CLK_DIV-1.
REQ-015 On pix_tick, hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
REQ-016 vCount wraps from V_TOTAL-1 to 0 together with the hCount wrap; no other vCount change occurs.
REQ-017 Counters hold their value in all clks without pix_tick.
REQ-018 hCount, vCount, bright, hSync, vSync are registered and update in the same clk (the clk after pix_tick), so all five are always mutually consistent.
REQ-019 bright=1 iff 144<=hCount<=783 and 35<=vCount<=514 (visible pixels start at hCount 144 and vCount 35).
REQ-020 hSync=0 iff hCount<96; vSync=0 iff vCount<2.
REQ-021 frame_start is a registered one-clk pulse asserted in the clk where counts first become (0,0) after a wrap; it is never asserted during reset.
REQ-022 Counter arithmetic is 10-bit unsigned, and a value >= H_TOTAL or >= V_TOTAL is never produced.
REQ-023 With CLK_DIV=1, pix_tick is held high and counts advance every clk.

Reset
REQ-024 While rst=0 at posedge clk: divider=0, hCount=0, vCount=0, bright=0, hSync=0, vSync=0, pix_tick=0, frame_start=0, frame_cnt=0.
REQ-025 Reset asserted mid-line or mid-frame aborts the frame immediately, with no frame_start and no frame_cnt increment.
REQ-026 First pix_tick occurs CLK_DIV clks after rst rises, and the first increment is hCount 0->1.

Configuration
REQ-027 Macro VGA_FRAME_CNT_EN defined: frame_cnt increments by 1, modulo 2^16, in the same clk as each frame_start.
REQ-028 Macro VGA_FRAME_CNT_EN undefined: frame_cnt is tied to 0 and no counter register is synthesised.

Structure
REQ-029 Package vga_timing_pkg holds the constants H_VIS_START=144, H_VIS_END=783, V_VIS_START=35, V_VIS_END=514, H_SYNC_W=96, V_SYNC_W=2 and the defaults H_TOTAL=800, V_TOTAL=525. The sprite controllers import the same constants.
REQ-030 Sub-module vga_pix_tick implements the CLK_DIV divider and pix_tick; vga_timing_gen instantiates it once.

Verification
REQ-031 Release rst, CLK_DIV=4 -> pix_tick at clk 4, 8, 12, ...; hCount=1 at clk 5; hSync=0 until hCount reaches 96.
REQ-032 Run to hCount=799, vCount=0, then one pix_tick -> hCount=0, vCount=1, with no frame_start.
REQ-033 Run to hCount=799, vCount=524, then one pix_tick -> hCount=0, vCount=0, frame_start pulses for exactly 1 clk, and frame_cnt goes 0->1 with the macro defined (stays 0 without it).
REQ-034 Sweep one full frame -> exactly 640*480=307200 pix_tick clks with bright=1; bright goes 0->1 at (144,35) and 1->0 at (784,35).
REQ-035 Assert rst at hCount=400, vCount=200 for 1 clk -> all outputs are 0 next clk; no frame_start; frame_cnt=0.
REQ-036 CLK_DIV=1 -> hCount advances every clk, and a full frame takes 420000 clks.
